// File: rtl/sat_pkg.sv
`default_nettype none
//============================================================================
// Module      : sat_pkg
// Description : Shared encodings for the SAT clause/BCP blocks.
//               Literal codes (2 bits per variable in a clause), value codes
//               (3 bits per variable: bit2 = implied flag, [1:0] = value) and
//               the BCP sequencer state enum.
// Revision    : 1.0 - initial release
//============================================================================
package sat_pkg;

    // Literal encoding inside a clause word
    localparam logic [1:0] LIT_NONE  = 2'b00;
    localparam logic [1:0] LIT_POS   = 2'b01;
    localparam logic [1:0] LIT_NEG   = 2'b10;

    // Variable value encoding, bits [1:0] of each 3-bit field
    localparam logic [1:0] VAL_FREE  = 2'b00;
    localparam logic [1:0] VAL_TRUE  = 2'b01;
    localparam logic [1:0] VAL_FALSE = 2'b10;

    // Position of the "implied" flag inside each 3-bit field
    localparam int IMP_BIT = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        EVAL = 3'd2,
        NEXT = 3'd3,
        DONE = 3'd4
    } bcp_state_t;

endpackage
`default_nettype wire

// File: rtl/clause_bcp_ctrl_merge.sv
`default_nettype none
//============================================================================
// Module      : bcp_merge
// Description : Combinational merge of an evaluator result into the working
//               value vector. A variable takes the returned value only when
//               it is currently free and the evaluator marked it as implied
//               with a concrete value.
// Ports       : i_cur     - working vector (3 bits per variable)
//               i_ret     - vector returned by the clause evaluator
//               o_merged  - merged vector
//               o_changed - at least one variable was newly assigned
// Revision    : 1.0 - initial release
//============================================================================
module bcp_merge
    import sat_pkg::*;
#(
    parameter int NUM_VARS = 8
) (
    input  logic [NUM_VARS*3-1:0] i_cur,
    input  logic [NUM_VARS*3-1:0] i_ret,
    output logic [NUM_VARS*3-1:0] o_merged,
    output logic                  o_changed
);

    logic [NUM_VARS-1:0] w_take;

    for (genvar gi = 0; gi < NUM_VARS; gi++) begin : g_var
        assign w_take[gi] = (i_cur[3*gi +: 2] == VAL_FREE)
                          && i_ret[3*gi + IMP_BIT]
                          && (i_ret[3*gi +: 2] != VAL_FREE);
        assign o_merged[3*gi +: 3] = w_take[gi] ? i_ret[3*gi +: 3] : i_cur[3*gi +: 3];
    end

    assign o_changed = |w_take;

endmodule
`default_nettype wire

// File: rtl/clause_bcp_ctrl.sv
`default_nettype none
//============================================================================
// Module      : clause_bcp_ctrl
// Description : Boolean constraint propagation sequencer. Holds a small
//               clause bank, presents one clause at a time to a shared
//               clause1 evaluator and merges returned implications into a
//               working vector, repeating passes until a fixed point or a
//               conflict.
// Ports       : clk/rst              - clock, synchronous active-high reset
//               wr_i/wr_addr_i/clause_i/clause_len_i - bank write (IDLE only)
//               start_i/var_value_i  - start a run on the given vector
//               var_value_o          - working/result vector
//               busy_o/done_o        - run in progress / completion pulse
//               conflict_o/conflict_idx_o - sticky conflict flag and slot
//               c_*                  - interface to the clause1 evaluator
// Options     : BCP_SKIP_SAT_EN - skip slots already found satisfied in an
//               earlier pass of the same run.
// Revision    : 1.0 - initial release
//============================================================================
module clause_bcp_ctrl
    import sat_pkg::*;
#(
    parameter  int NUM_VARS    = 8,
    parameter  int NUM_CLAUSES = 16,
    parameter  int WIDTH_C_LEN = 5,
    localparam int AW          = $clog2(NUM_CLAUSES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_i,
    input  logic [AW-1:0]          wr_addr_i,
    input  logic [NUM_VARS*2-1:0]  clause_i,
    input  logic [WIDTH_C_LEN-1:0] clause_len_i,
    input  logic                   start_i,
    input  logic [NUM_VARS*3-1:0]  var_value_i,
    output logic [NUM_VARS*3-1:0]  var_value_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   conflict_o,
    output logic [AW-1:0]          conflict_idx_o,
    output logic                   c_wr_o,
    output logic [NUM_VARS*2-1:0]  c_clause_o,
    output logic [WIDTH_C_LEN-1:0] c_clause_len_o,
    output logic [NUM_VARS*3-1:0]  c_var_value_o,
    input  logic [NUM_VARS*3-1:0]  c_var_value_i,
    input  logic                   c_sat_i,
    input  logic                   c_conflict_i
);

    bcp_state_t             r_state, w_next;
    logic [NUM_VARS*2-1:0]  r_bank_clause [NUM_CLAUSES];
    logic [WIDTH_C_LEN-1:0] r_bank_len    [NUM_CLAUSES];
    logic [NUM_VARS*3-1:0]  r_work;
    logic [AW-1:0]          r_slot;
    logic                   r_changed;
    logic                   r_conflict;
    logic [AW-1:0]          r_conflict_idx;

    logic [NUM_VARS*3-1:0]  w_merged;
    logic                   w_merge_changed;
    logic                   w_masked;
    logic                   w_skip;
    logic                   w_last;

`ifdef BCP_SKIP_SAT_EN
    logic [NUM_CLAUSES-1:0] r_sat_mask;
    assign w_masked = r_sat_mask[r_slot];
`else
    logic w_unused_sat;
    assign w_unused_sat = c_sat_i;
    assign w_masked     = 1'b0;
`endif

    assign w_skip = (r_bank_len[r_slot] == '0) || w_masked;
    assign w_last = (r_slot == AW'(NUM_CLAUSES - 1));

    bcp_merge #(
        .NUM_VARS (NUM_VARS)
    ) u_merge (
        .i_cur     (r_work),
        .i_ret     (c_var_value_i),
        .o_merged  (w_merged),
        .o_changed (w_merge_changed)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start_i) w_next = LOAD;
            LOAD: w_next = w_skip ? NEXT : EVAL;
            EVAL: w_next = c_conflict_i ? DONE : NEXT;
            NEXT: w_next = (!w_last || r_changed) ? LOAD : DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_work         <= '0;
            r_slot         <= '0;
            r_changed      <= 1'b0;
            r_conflict     <= 1'b0;
            r_conflict_idx <= '0;
            for (int i = 0; i < NUM_CLAUSES; i++) begin
                r_bank_clause[i] <= '0;
                r_bank_len[i]    <= '0;
            end
`ifdef BCP_SKIP_SAT_EN
            r_sat_mask     <= '0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (wr_i) begin
                        r_bank_clause[wr_addr_i] <= clause_i;
                        r_bank_len[wr_addr_i]    <= clause_len_i;
                    end
                    if (start_i) begin
                        r_work     <= var_value_i;
                        r_conflict <= 1'b0;
                        r_changed  <= 1'b0;
                        r_slot     <= '0;
`ifdef BCP_SKIP_SAT_EN
                        r_sat_mask <= '0;
`endif
                    end
                end
                EVAL: begin
                    // On conflict the working vector is left untouched so the
                    // caller sees the state that produced the conflict.
                    if (c_conflict_i) begin
                        r_conflict     <= 1'b1;
                        r_conflict_idx <= r_slot;
                    end else begin
                        r_work <= w_merged;
                        if (w_merge_changed) r_changed <= 1'b1;
                    end
`ifdef BCP_SKIP_SAT_EN
                    if (c_sat_i) r_sat_mask[r_slot] <= 1'b1;
`endif
                end
                NEXT: begin
                    if (!w_last) begin
                        r_slot <= r_slot + AW'(1);
                    end else if (r_changed) begin
                        r_changed <= 1'b0;
                        r_slot    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign var_value_o    = r_work;
    assign busy_o         = (r_state != IDLE);
    assign done_o         = (r_state == DONE);
    assign conflict_o     = r_conflict;
    assign conflict_idx_o = r_conflict_idx;
    assign c_wr_o         = (r_state == LOAD) && !w_skip;
    assign c_clause_o     = c_wr_o ? r_bank_clause[r_slot] : '0;
    assign c_clause_len_o = c_wr_o ? r_bank_len[r_slot]    : '0;
    assign c_var_value_o  = r_work;

endmodule
`default_nettype wire
